// File: rtl/bram_responder.sv
// -----------------------------------------------------------------------------
// bram_responder
//
// Responder end of the BRAM request/response interface. It owns a
// 2**ADDR_W x DATA_W synchronous-read memory and serves read and write
// requests presented over a valid/ready handshake. Every accepted request
// produces exactly one response, delivered in acceptance order through a
// small buffered valid/ready response channel. Saturating read and write
// counters are exported for LEDs and debug.
//
// Data path:
//   accept edge N   : memory written (write) or read into mem_rdata_q (read);
//                     request captured into the stage register.
//   edge N+1        : stage entry pushed into the response FIFO.
//   after edge N+1  : o_rsp_valid high (two cycles from accept to response).
//
// Flow control is credit based: 'outstanding' counts every request that
// has been accepted but not yet popped, whether it sits in the stage or in
// the FIFO. Limiting it to RSP_DEPTH guarantees the FIFO always has room
// when the stage pushes, so the stage never has to stall.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_req_valid  request present
//   o_req_ready  responder can accept a request (registered state only)
//   i_req_wr     1 = write, 0 = read
//   i_req_addr   request address
//   i_req_wdata  write data (ignored for reads)
//   o_rsp_valid  response present at FIFO head
//   i_rsp_ready  initiator consumes the response
//   o_rsp_wr     response belongs to a write
//   o_rsp_addr   address of the originating request
//   o_rsp_data   read data for reads, echoed write data for writes
//   o_rd_count   accepted reads, saturating
//   o_wr_count   accepted writes, saturating
// -----------------------------------------------------------------------------
module bram_responder #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 16,
  parameter int RSP_DEPTH = 4,
  parameter int COUNT_W   = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_req_valid,
  output logic               o_req_ready,
  input  logic               i_req_wr,
  input  logic [ADDR_W-1:0]  i_req_addr,
  input  logic [DATA_W-1:0]  i_req_wdata,
  output logic               o_rsp_valid,
  input  logic               i_rsp_ready,
  output logic               o_rsp_wr,
  output logic [ADDR_W-1:0]  o_rsp_addr,
  output logic [DATA_W-1:0]  o_rsp_data,
  output logic [COUNT_W-1:0] o_rd_count,
  output logic [COUNT_W-1:0] o_wr_count
);

  localparam int MEM_DEPTH = 1 << ADDR_W;
  localparam int PTR_W     = $clog2(RSP_DEPTH);
  localparam int CNT_W     = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(RSP_DEPTH);

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } rsp_t;

  // Memory and its registered read port
  logic [DATA_W-1:0] mem [MEM_DEPTH];
  logic [DATA_W-1:0] mem_rdata_q;

  // Handshake events
  logic accept;
  logic pop;
  logic push;

  // Stage register between the memory and the response FIFO
  logic              stage_valid_q, stage_valid_d;
  logic              stage_wr_q,    stage_wr_d;
  logic [ADDR_W-1:0] stage_addr_q,  stage_addr_d;
  logic [DATA_W-1:0] stage_wdata_q, stage_wdata_d;

  // Response FIFO
  rsp_t             fifo_q [RSP_DEPTH];
  rsp_t             fifo_d [RSP_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
  rsp_t             push_entry;
  rsp_t             head_entry;

  // Credit counter and statistics
  logic [CNT_W-1:0]   outstanding_q, outstanding_d;
  logic [COUNT_W-1:0] rd_count_q, rd_count_d;
  logic [COUNT_W-1:0] wr_count_q, wr_count_d;

  // Handshakes. Ready depends only on the registered credit count so that
  // no combinational path exists from i_req_valid or i_rsp_ready.
  assign o_req_ready = (outstanding_q < DEPTH_CNT);
  assign o_rsp_valid = (fifo_cnt_q != '0);
  assign accept      = i_req_valid && o_req_ready;
  assign pop         = o_rsp_valid && i_rsp_ready;
  assign push        = stage_valid_q;

  // The memory array has no reset so it maps onto block RAM; contents
  // survive a reset. A write and a read can never share an edge because
  // there is a single request port, so read data is always old contents.
  always_ff @(posedge i_clk) begin
    if (accept && i_req_wr) begin
      mem[i_req_addr] <= i_req_wdata;
    end
    if (accept && !i_req_wr) begin
      mem_rdata_q <= mem[i_req_addr];
    end
  end

  // Stage capture: the stage is valid for exactly the cycle after an
  // accept, and always drains into the FIFO on the following edge.
  always_comb begin
    stage_valid_d = accept;
    stage_wr_d    = stage_wr_q;
    stage_addr_d  = stage_addr_q;
    stage_wdata_d = stage_wdata_q;
    if (accept) begin
      stage_wr_d    = i_req_wr;
      stage_addr_d  = i_req_addr;
      stage_wdata_d = i_req_wdata;
    end
  end

  // Entry pushed from the stage: reads take the memory output, writes echo
  // the captured write data.
  always_comb begin
    push_entry.wr   = stage_wr_q;
    push_entry.addr = stage_addr_q;
    push_entry.data = stage_wr_q ? stage_wdata_q : mem_rdata_q;
  end

  // FIFO bookkeeping. The credit limit guarantees room on every push, so
  // no full check is needed on the write side.
  always_comb begin
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (push) begin
      fifo_d[wr_ptr_q] = push_entry;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  // Head of the FIFO drives the response outputs directly; the head slot is
  // only overwritten after it has been popped, so outputs hold while stalled.
  assign head_entry = fifo_q[rd_ptr_q];
  assign o_rsp_wr   = head_entry.wr;
  assign o_rsp_addr = head_entry.addr;
  assign o_rsp_data = head_entry.data;

  // Credits cover both the stage and the FIFO: taken on accept, returned on pop.
  always_comb begin
    case ({accept, pop})
      2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
      2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  // Statistics counters stop at all-ones rather than wrapping.
  always_comb begin
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    if (accept && !i_req_wr && (rd_count_q != '1)) begin
      rd_count_d = rd_count_q + COUNT_W'(1);
    end
    if (accept && i_req_wr && (wr_count_q != '1)) begin
      wr_count_d = wr_count_q + COUNT_W'(1);
    end
  end

  assign o_rd_count = rd_count_q;
  assign o_wr_count = wr_count_q;

  // State registers. Resetting the FIFO storage makes the response outputs
  // read zero straight out of reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stage_valid_q <= 1'b0;
      stage_wr_q    <= 1'b0;
      stage_addr_q  <= '0;
      stage_wdata_q <= '0;
      fifo_q        <= '{default: '0};
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fifo_cnt_q    <= '0;
      outstanding_q <= '0;
      rd_count_q    <= '0;
      wr_count_q    <= '0;
    end else begin
      stage_valid_q <= stage_valid_d;
      stage_wr_q    <= stage_wr_d;
      stage_addr_q  <= stage_addr_d;
      stage_wdata_q <= stage_wdata_d;
      fifo_q        <= fifo_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fifo_cnt_q    <= fifo_cnt_d;
      outstanding_q <= outstanding_d;
      rd_count_q    <= rd_count_d;
      wr_count_q    <= wr_count_d;
    end
  end

endmodule

// File: tb/tb_bram_responder.sv
// -----------------------------------------------------------------------------
// tb_bram_responder
//
// Scoreboard bench for bram_responder. Stimulus pushes the hand-computed
// expected response into a queue at the edge a request is accepted; an
// independent monitor pops and compares whenever a response is consumed,
// and also checks that a stalled response holds steady. A second instance
// with 4-bit counters exercises counter saturation.
// -----------------------------------------------------------------------------
module tb_bram_responder;

  typedef struct packed {
    logic        wr;
    logic [7:0]  addr;
    logic [15:0] data;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_wr;
  logic [7:0]  rsp_addr;
  logic [15:0] rsp_data;
  logic [15:0] rd_count;
  logic [15:0] wr_count;

  // Saturation instance
  logic        s_req_valid;
  logic        s_req_ready;
  logic        s_req_wr;
  logic [7:0]  s_req_addr;
  logic [15:0] s_req_wdata;
  logic        s_rsp_valid;
  logic        s_rsp_ready;
  logic        s_rsp_wr;
  logic [7:0]  s_rsp_addr;
  logic [15:0] s_rsp_data;
  logic [3:0]  s_rd_count;
  logic [3:0]  s_wr_count;

  int   checks;
  int   errors;
  int   ready_stalls;
  int   exp_rd;
  int   exp_wr;
  logic rand_ready;
  exp_t exp_q[$];

  bram_responder dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_wr    (req_wr),
    .i_req_addr  (req_addr),
    .i_req_wdata (req_wdata),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_wr    (rsp_wr),
    .o_rsp_addr  (rsp_addr),
    .o_rsp_data  (rsp_data),
    .o_rd_count  (rd_count),
    .o_wr_count  (wr_count)
  );

  bram_responder #(.COUNT_W(4)) dut_sat (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (s_req_valid),
    .o_req_ready (s_req_ready),
    .i_req_wr    (s_req_wr),
    .i_req_addr  (s_req_addr),
    .i_req_wdata (s_req_wdata),
    .o_rsp_valid (s_rsp_valid),
    .i_rsp_ready (s_rsp_ready),
    .o_rsp_wr    (s_rsp_wr),
    .o_rsp_addr  (s_rsp_addr),
    .o_rsp_data  (s_rsp_data),
    .o_rd_count  (s_rd_count),
    .o_wr_count  (s_wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scalar comparison with pass/fail bookkeeping
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Advance to just after the next rising edge; optionally jitter rsp_ready
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) rsp_ready = 1'($urandom_range(0, 1));
  endtask

  // Offer one request and wait for it to be accepted, scoring the expected response
  task automatic applyStimulus(input logic wr, input logic [7:0] addr,
                               input logic [15:0] wdata, input logic [15:0] exp_data);
    int   guard;
    logic rdy;
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = wdata;
    guard     = 0;
    forever begin
      @(negedge clk);
      rdy = req_ready;
      if (!rdy) ready_stalls++;
      @(posedge clk);
      if (rdy) begin
        exp_q.push_back(exp_t'{wr, addr, exp_data});
        if (wr) exp_wr++;
        else exp_rd++;
      end
      #1;
      if (rand_ready) rsp_ready = 1'($urandom_range(0, 1));
      if (rdy) break;
      guard++;
      if (guard > 100) begin
        checks++;
        errors++;
        $display("[TB] FAIL accept_timeout actual=not_accepted expected=accepted addr=%0h", addr);
        break;
      end
    end
    req_valid = 1'b0;
  endtask

  // Wait until every expected response has been consumed and the DUT is empty
  task automatic drain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || rsp_valid) && guard < 200) begin
      tick();
      guard++;
    end
    checkOutput("drain_done", 32'(exp_q.size() == 0 && !rsp_valid), 32'd1);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    exp_q.delete();
    exp_rd = 0;
    exp_wr = 0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic satWrites(input int n);
    int   acc;
    int   guard;
    logic rdy;
    acc   = 0;
    guard = 0;
    s_req_valid = 1'b1;
    s_req_wr    = 1'b1;
    while (acc < n && guard < 200) begin
      s_req_addr  = 8'(acc);
      s_req_wdata = 16'(acc);
      @(negedge clk);
      rdy = s_req_ready;
      @(posedge clk);
      #1;
      if (rdy) acc++;
      guard++;
    end
    s_req_valid = 1'b0;
    checkOutput("sat_accepts", 32'(acc), 32'(n));
  endtask

  // Monitor: compares each consumed response against the scoreboard and
  // checks that a stalled response stays put.
  initial begin
    logic        prev_stall;
    logic [24:0] prev_payload;
    exp_t        e;
    prev_stall   = 1'b0;
    prev_payload = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
        continue;
      end
      if (prev_stall) begin
        checkOutput("hold_valid", 32'(rsp_valid), 32'd1);
        checkOutput("hold_payload", 32'({rsp_wr, rsp_addr, rsp_data}), 32'(prev_payload));
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_rsp actual=%0h expected=none", {rsp_wr, rsp_addr, rsp_data});
        end else begin
          e = exp_q.pop_front();
          checkOutput("rsp", 32'({rsp_wr, rsp_addr, rsp_data}), 32'(e));
        end
      end
      prev_stall   = rsp_valid && !rsp_ready;
      prev_payload = {rsp_wr, rsp_addr, rsp_data};
    end
  end

  // Watchdog
  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    checks       = 0;
    errors       = 0;
    ready_stalls = 0;
    exp_rd       = 0;
    exp_wr       = 0;
    rand_ready   = 1'b0;
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_wr       = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;
    rsp_ready    = 1'b1;
    s_req_valid  = 1'b0;
    s_req_wr     = 1'b0;
    s_req_addr   = '0;
    s_req_wdata  = '0;
    s_rsp_ready  = 1'b1;

    // Reset state
    tick();
    tick();
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
    checkOutput("reset_rsp_fields", 32'({rsp_wr, rsp_addr, rsp_data}), 32'd0);
    checkOutput("reset_rd_count", 32'(rd_count), 32'd0);
    checkOutput("reset_wr_count", 32'(wr_count), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single transaction with latency check on the read
    applyStimulus(1'b1, 8'h07, 16'h0005, 16'h0005);
    drain();
    applyStimulus(1'b0, 8'h07, 16'h0000, 16'h0005);
    checkOutput("latency_n1", 32'(rsp_valid), 32'd0);
    tick();
    checkOutput("latency_n2", 32'(rsp_valid), 32'd1);
    drain();
    checkOutput("single_wr_count", 32'(wr_count), 32'd1);
    checkOutput("single_rd_count", 32'(rd_count), 32'd1);

    // Backpressure: only RSP_DEPTH requests accepted while responses are blocked
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'(8'h20 + i), 16'(16'h1000 + i), 16'(16'h1000 + i));
    drain();
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'(8'h20 + i), 16'h0, 16'(16'h1000 + i));
    req_valid = 1'b1;
    req_wr    = 1'b0;
    req_addr  = 8'h24;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("bp_ready_low", 32'(req_ready), 32'd0);
      tick();
    end
    checkOutput("bp_rd_count", 32'(rd_count), 32'd5);
    rsp_ready = 1'b1;
    applyStimulus(1'b0, 8'h24, 16'h0, 16'h1004);
    applyStimulus(1'b0, 8'h25, 16'h0, 16'h1005);
    drain();

    // Streaming: one request per cycle, ready must never drop
    doReset();
    ready_stalls = 0;
    for (int k = 0; k < 256; k++) applyStimulus(1'b1, 8'(k), 16'(5 + 13 * k), 16'(5 + 13 * k));
    for (int k = 0; k < 256; k++) applyStimulus(1'b0, 8'(k), 16'h0, 16'(5 + 13 * k));
    checkOutput("stream_no_stall", 32'(ready_stalls), 32'd0);
    checkOutput("stream_wr_count", 32'(wr_count), 32'd256);
    checkOutput("stream_rd_count", 32'(rd_count), 32'd256);
    drain();

    // Read-after-write hazard, then ordering under random backpressure
    applyStimulus(1'b1, 8'h0A, 16'h1234, 16'h1234);
    applyStimulus(1'b0, 8'h0A, 16'h0, 16'h1234);
    rand_ready = 1'b1;
    applyStimulus(1'b1, 8'h0A, 16'hBEEF, 16'hBEEF);
    applyStimulus(1'b0, 8'h0A, 16'h0, 16'hBEEF);
    applyStimulus(1'b1, 8'h0B, 16'h0001, 16'h0001);
    applyStimulus(1'b0, 8'h0B, 16'h0, 16'h0001);
    applyStimulus(1'b0, 8'h0C, 16'h0, 16'h00A1);
    applyStimulus(1'b0, 8'h07, 16'h0, 16'h0060);
    for (int i = 0; i < 8; i++) tick();
    rand_ready = 1'b0;
    rsp_ready  = 1'b1;
    drain();

    // Reset with responses outstanding; memory must survive
    rsp_ready = 1'b0;
    applyStimulus(1'b0, 8'h30, 16'h0, 16'h0275);
    applyStimulus(1'b0, 8'h31, 16'h0, 16'h0282);
    applyStimulus(1'b0, 8'h32, 16'h0, 16'h028F);
    tick();
    tick();
    rst_n = 1'b0;
    exp_q.delete();
    exp_rd = 0;
    exp_wr = 0;
    @(negedge clk);
    checkOutput("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("midrst_req_ready", 32'(req_ready), 32'd1);
    checkOutput("midrst_rd_count", 32'(rd_count), 32'd0);
    checkOutput("midrst_wr_count", 32'(wr_count), 32'd0);
    tick();
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    tick();
    checkOutput("postrst_rsp_valid", 32'(rsp_valid), 32'd0);
    applyStimulus(1'b0, 8'h0A, 16'h0, 16'hBEEF);
    drain();
    checkOutput("postrst_rd_count", 32'(rd_count), 32'd1);

    // Saturation on the 4-bit counter instance
    satWrites(15);
    tick();
    checkOutput("sat_wr_15", 32'(s_wr_count), 32'd15);
    satWrites(5);
    tick();
    checkOutput("sat_wr_hold", 32'(s_wr_count), 32'd15);
    checkOutput("sat_rd_zero", 32'(s_rd_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
